// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
//   Shares the single-port data memory between the CPU MEM stage (m0) and
//   the DMA/debug engine (m1). Masters take turns round-robin. m1 may also
//   hold the memory for up to LOCK_MAX back-to-back grants by asserting m1_lock.
//   The block builds the DM byte enables from size and address. It suppresses
//   misaligned accesses and accesses outside the DM window, and returns a
//   registered one-cycle response to the master that was granted.
//
// Ports
//   clk, reset                  clock, asynchronous active-low reset
//   mX_req/we/addr/wdata/size   request side of master X (X = 0, 1)
//   m1_lock                     m1 asks to keep ownership for back-to-back grants
//   mX_gnt                      combinational grant, at most one per cycle
//   mX_rvalid/rdata/err         registered response, one cycle after mX_gnt
//   stall_cpu                   m0 is requesting but is not granted this cycle
//   dm_a/dm_wd/dm_we/dm_be      drive the DM port
//   dm_rd                       combinational DM read data
module dm_port_arbiter #(
    parameter logic [31:0] DM_LIMIT = 32'h0000_3000,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [1:0]  m0_size,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [1:0]  m1_size,
    input  logic        m1_lock,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        stall_cpu,
    output logic [31:0] dm_a,
    output logic [31:0] dm_wd,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    input  logic [31:0] dm_rd
);

    localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

    typedef enum logic {ARB, LOCK} state_t;

    state_t      state_q, state_d;
    logic        rrPtr_q, rrPtr_d;
    logic [7:0]  lockCnt_q, lockCnt_d;
    logic        gnt0, gnt1, lockHold;
    logic        err0, err1;
    logic [3:0]  be0, be1;
    logic        m0Rvalid_q, m1Rvalid_q, m0Err_q, m1Err_q;
    logic [31:0] m0Rdata_q, m1Rdata_q;
    logic        selErr, selWe, accessOk;
    logic [3:0]  selBe;
    logic [31:0] selAddr, selWdata;

    function automatic logic [3:0] calcBe(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    calcBe = 4'b0001 << a;
            2'd1:    calcBe = a[1] ? 4'b1100 : 4'b0011;
            2'd2:    calcBe = 4'b1111;
            default: calcBe = 4'b0000;
        endcase
    endfunction

    function automatic logic calcErr(input logic [1:0] size, input logic [31:0] addr);
        calcErr = (addr >= DM_LIMIT);
        case (size)
            2'd1:    calcErr = calcErr | addr[0];
            2'd2:    calcErr = calcErr | (|addr[1:0]);
            2'd3:    calcErr = 1'b1;
            default: calcErr = calcErr;
        endcase
    endfunction

    assign err0 = calcErr(m0_size, m0_addr);
    assign err1 = calcErr(m1_size, m1_addr);
    assign be0  = calcBe(m0_size, m0_addr[1:0]);
    assign be1  = calcBe(m1_size, m1_addr[1:0]);

    // m1 keeps the port while it is still locked and under its grant budget.
    // Otherwise we arbitrate normally. Every m1 grant leaves rr_ptr at 0, so a
    // lock exit hands a waiting m0 the grant in that same cycle.
    assign lockHold = (state_q == LOCK) && m1_req && m1_lock && (lockCnt_q < LOCK_MAX_C);

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_d   = state_q;
        rrPtr_d   = rrPtr_q;
        lockCnt_d = lockCnt_q;
        if (lockHold) begin
            gnt1      = 1'b1;
            lockCnt_d = lockCnt_q + 8'd1;
        end else begin
            if (m0_req && (!m1_req || !rrPtr_q)) begin
                gnt0 = 1'b1;
            end else if (m1_req) begin
                gnt1 = 1'b1;
            end
            state_d   = ARB;
            lockCnt_d = 8'd0;
            if (gnt0) begin
                rrPtr_d = 1'b1;
            end else if (gnt1) begin
                rrPtr_d = 1'b0;
                if (m1_lock) begin
                    state_d   = LOCK;
                    lockCnt_d = 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ARB;
            rrPtr_q   <= 1'b0;
            lockCnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            rrPtr_q   <= rrPtr_d;
            lockCnt_q <= lockCnt_d;
        end
    end

    // Grants are forced low while reset is held. This keeps the DM port quiet
    // during reset even if the masters are still requesting.
    assign m0_gnt    = gnt0 & reset;
    assign m1_gnt    = gnt1 & reset;
    assign stall_cpu = m0_req & ~m0_gnt;

    assign selErr   = m1_gnt ? err1 : err0;
    assign selWe    = m1_gnt ? m1_we : m0_we;
    assign selBe    = m1_gnt ? be1 : be0;
    assign selAddr  = m1_gnt ? m1_addr : m0_addr;
    assign selWdata = m1_gnt ? m1_wdata : m0_wdata;
    assign accessOk = (m0_gnt | m1_gnt) & ~selErr;

    assign dm_we = accessOk & selWe;
    assign dm_be = accessOk ? selBe : 4'b0000;
    assign dm_a  = accessOk ? selAddr : 32'h0;
    assign dm_wd = accessOk ? selWdata : 32'h0;

    // Responses are single-cycle pulses. Loads capture the DM word on the
    // grant edge. Stores and suppressed accesses return zero data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m0Rvalid_q <= 1'b0;
            m0Err_q    <= 1'b0;
            m0Rdata_q  <= 32'h0;
            m1Rvalid_q <= 1'b0;
            m1Err_q    <= 1'b0;
            m1Rdata_q  <= 32'h0;
        end else begin
            m0Rvalid_q <= m0_gnt;
            m0Err_q    <= m0_gnt & err0;
            m0Rdata_q  <= (m0_gnt && !err0 && !m0_we) ? dm_rd : 32'h0;
            m1Rvalid_q <= m1_gnt;
            m1Err_q    <= m1_gnt & err1;
            m1Rdata_q  <= (m1_gnt && !err1 && !m1_we) ? dm_rd : 32'h0;
        end
    end

    assign m0_rvalid = m0Rvalid_q;
    assign m0_err    = m0Err_q;
    assign m0_rdata  = m0Rdata_q;
    assign m1_rvalid = m1Rvalid_q;
    assign m1_err    = m1Err_q;
    assign m1_rdata  = m1Rdata_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter
//   Table-driven bench for dm_port_arbiter, instantiated with LOCK_MAX = 3.
//   Each vector gives the request inputs and the expected grant and DM port
//   values for that cycle. A grant pushes the expected response onto a queue.
//   The entry is popped in the following cycle and compared with the
//   registered response.
module tb_dm_port_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, dm_rd;
    logic [1:0]  m0_size, m1_size;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, stall_cpu, dm_we;
    logic [31:0] m0_rdata, m1_rdata, dm_a, dm_wd;
    logic [3:0]  dm_be;

    typedef struct {
        logic        m0Req;
        logic        m0We;
        logic [31:0] m0Addr;
        logic [31:0] m0Wdata;
        logic [1:0]  m0Size;
        logic        m1Req;
        logic        m1We;
        logic [31:0] m1Addr;
        logic [31:0] m1Wdata;
        logic [1:0]  m1Size;
        logic        m1Lock;
        logic [31:0] dmRd;
        logic [1:0]  expGnt;
        logic        expWe;
        logic [3:0]  expBe;
        logic        expErr;
        logic [31:0] expRdata;
        logic [31:0] expAddr;
    } vec_t;

    typedef struct {
        logic        master;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    vec_t  vecs[28];
    resp_t respQ[$];
    int    checks = 0;
    int    fails  = 0;

    dm_port_arbiter #(.DM_LIMIT(32'h0000_3000), .LOCK_MAX(3)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_size(m0_size),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_size(m1_size),
        .m1_lock(m1_lock),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .stall_cpu(stall_cpu), .dm_a(dm_a), .dm_wd(dm_wd), .dm_we(dm_we), .dm_be(dm_be),
        .dm_rd(dm_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        m0_req   = v.m0Req;
        m0_we    = v.m0We;
        m0_addr  = v.m0Addr;
        m0_wdata = v.m0Wdata;
        m0_size  = v.m0Size;
        m1_req   = v.m1Req;
        m1_we    = v.m1We;
        m1_addr  = v.m1Addr;
        m1_wdata = v.m1Wdata;
        m1_size  = v.m1Size;
        m1_lock  = v.m1Lock;
        dm_rd    = v.dmRd;
    endtask

    // Compares the response to the previous cycle's grant, then this cycle's
    // combinational outputs. The expected response for this cycle is queued last.
    task automatic checkOutput(input string tag, input vec_t v);
        resp_t r;
        if (respQ.size() != 0) begin
            r = respQ.pop_front();
            checkVal({tag, " m0_rvalid"}, 32'(m0_rvalid), 32'(!r.master));
            checkVal({tag, " m1_rvalid"}, 32'(m1_rvalid), 32'(r.master));
            checkVal({tag, " resp_err"}, 32'(r.master ? m1_err : m0_err), 32'(r.err));
            checkVal({tag, " resp_rdata"}, r.master ? m1_rdata : m0_rdata, r.rdata);
        end else begin
            checkVal({tag, " rvalid_idle"}, {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
            checkVal({tag, " rdata_idle"}, m0_rdata | m1_rdata, 32'h0);
        end
        checkVal({tag, " gnt"}, {30'h0, m1_gnt, m0_gnt}, {30'h0, v.expGnt});
        checkVal({tag, " stall_cpu"}, 32'(stall_cpu), 32'(v.m0Req & ~v.expGnt[0]));
        checkVal({tag, " dm_we"}, 32'(dm_we), 32'(v.expWe));
        checkVal({tag, " dm_be"}, 32'(dm_be), 32'(v.expBe));
        if (!v.expErr) begin
            checkVal({tag, " dm_a"}, dm_a, v.expAddr);
        end
        if (v.expWe) begin
            checkVal({tag, " dm_wd"}, dm_wd, v.expGnt[1] ? v.m1Wdata : v.m0Wdata);
        end
        if (v.expGnt != 2'b00) begin
            respQ.push_back('{master: v.expGnt[1], err: v.expErr, rdata: v.expRdata});
        end
    endtask

    initial begin
        vec_t idle;
        vec_t st;
        idle = '{1'b0,1'b0,32'h0,32'h0,2'd0, 1'b0,1'b0,32'h0,32'h0,2'd0,1'b0, 32'h0, 2'b00,1'b0,4'h0,1'b0,32'h0,32'h0};

        // Contention without lock, then single-requester accesses covering byte enables and errors
        vecs[0]  = '{1'b1,1'b0,32'h20,32'h0,2'd2, 1'b1,1'b0,32'h40,32'h0,2'd2,1'b0, 32'h1111_1111, 2'b01,1'b0,4'hF,1'b0,32'h1111_1111,32'h20};
        vecs[1]  = '{1'b1,1'b0,32'h20,32'h0,2'd2, 1'b1,1'b0,32'h40,32'h0,2'd2,1'b0, 32'h2222_2222, 2'b10,1'b0,4'hF,1'b0,32'h2222_2222,32'h40};
        vecs[2]  = '{1'b1,1'b0,32'h20,32'h0,2'd2, 1'b1,1'b0,32'h40,32'h0,2'd2,1'b0, 32'h3333_3333, 2'b01,1'b0,4'hF,1'b0,32'h3333_3333,32'h20};
        vecs[3]  = '{1'b1,1'b0,32'h20,32'h0,2'd2, 1'b1,1'b0,32'h40,32'h0,2'd2,1'b0, 32'h4444_4444, 2'b10,1'b0,4'hF,1'b0,32'h4444_4444,32'h40};
        vecs[4]  = idle;
        vecs[5]  = '{1'b1,1'b1,32'h106,32'hAB,2'd0, 1'b0,1'b0,32'h0,32'h0,2'd0,1'b0, 32'h9999_9999, 2'b01,1'b1,4'h4,1'b0,32'h0,32'h106};
        vecs[6]  = '{1'b0,1'b0,32'h0,32'h0,2'd0, 1'b1,1'b0,32'h10,32'h0,2'd2,1'b0, 32'hDEAD_BEEF, 2'b10,1'b0,4'hF,1'b0,32'hDEAD_BEEF,32'h10};
        vecs[7]  = '{1'b1,1'b1,32'h3,32'h1234,2'd1, 1'b0,1'b0,32'h0,32'h0,2'd0,1'b0, 32'h5555_5555, 2'b01,1'b0,4'h0,1'b1,32'h0,32'h0};
        vecs[8]  = '{1'b1,1'b0,32'h3000,32'h0,2'd2, 1'b0,1'b0,32'h0,32'h0,2'd0,1'b0, 32'hCAFE_F00D, 2'b01,1'b0,4'h0,1'b1,32'h0,32'h0};
        vecs[9]  = '{1'b0,1'b0,32'h0,32'h0,2'd0, 1'b1,1'b1,32'h2,32'hBEEF,2'd1,1'b0, 32'h6666_6666, 2'b10,1'b1,4'hC,1'b0,32'h0,32'h2};
        vecs[10] = '{1'b1,1'b0,32'h2FFF,32'h0,2'd0, 1'b0,1'b0,32'h0,32'h0,2'd0,1'b0, 32'h1234_5678, 2'b01,1'b0,4'h8,1'b0,32'h1234_5678,32'h2FFF};
        vecs[11] = '{1'b0,1'b0,32'h0,32'h0,2'd0, 1'b1,1'b1,32'h2FFC,32'h0BAD_F00D,2'd2,1'b0, 32'h7777_7777, 2'b10,1'b1,4'hF,1'b0,32'h0,32'h2FFC};
        vecs[12] = '{1'b0,1'b0,32'h0,32'h0,2'd0, 1'b1,1'b0,32'h0,32'h0,2'd3,1'b0, 32'h8888_8888, 2'b10,1'b0,4'h0,1'b1,32'h0,32'h0};
        vecs[13] = '{1'b1,1'b1,32'h6,32'h5A5A,2'd2, 1'b0,1'b0,32'h0,32'h0,2'd0,1'b0, 32'hAAAA_AAAA, 2'b01,1'b0,4'h0,1'b1,32'h0,32'h0};
        vecs[14] = '{1'b0,1'b0,32'h0,32'h0,2'd0, 1'b1,1'b0,32'h1,32'h0,2'd1,1'b0, 32'hBBBB_BBBB, 2'b10,1'b0,4'h0,1'b1,32'h0,32'h0};
        vecs[15] = '{1'b1,1'b0,32'h2,32'h0,2'd1, 1'b0,1'b0,32'h0,32'h0,2'd0,1'b0, 32'hA5A5_5A5A, 2'b01,1'b0,4'hC,1'b0,32'hA5A5_5A5A,32'h2};
        vecs[16] = idle;
        // Lock with LOCK_MAX = 3: m1 three times, then m0, then round-robin again
        vecs[17] = '{1'b1,1'b0,32'h20,32'h0,2'd2, 1'b1,1'b0,32'h40,32'h0,2'd2,1'b1, 32'h101, 2'b10,1'b0,4'hF,1'b0,32'h101,32'h40};
        vecs[18] = '{1'b1,1'b0,32'h20,32'h0,2'd2, 1'b1,1'b0,32'h40,32'h0,2'd2,1'b1, 32'h102, 2'b10,1'b0,4'hF,1'b0,32'h102,32'h40};
        vecs[19] = '{1'b1,1'b0,32'h20,32'h0,2'd2, 1'b1,1'b0,32'h40,32'h0,2'd2,1'b1, 32'h103, 2'b10,1'b0,4'hF,1'b0,32'h103,32'h40};
        vecs[20] = '{1'b1,1'b0,32'h20,32'h0,2'd2, 1'b1,1'b0,32'h40,32'h0,2'd2,1'b1, 32'h104, 2'b01,1'b0,4'hF,1'b0,32'h104,32'h20};
        vecs[21] = '{1'b1,1'b0,32'h20,32'h0,2'd2, 1'b1,1'b0,32'h40,32'h0,2'd2,1'b1, 32'h105, 2'b10,1'b0,4'hF,1'b0,32'h105,32'h40};
        vecs[22] = '{1'b1,1'b0,32'h20,32'h0,2'd2, 1'b1,1'b0,32'h40,32'h0,2'd2,1'b0, 32'h106, 2'b01,1'b0,4'hF,1'b0,32'h106,32'h20};
        vecs[23] = '{1'b1,1'b0,32'h20,32'h0,2'd2, 1'b1,1'b0,32'h40,32'h0,2'd2,1'b0, 32'h107, 2'b10,1'b0,4'hF,1'b0,32'h107,32'h40};
        vecs[24] = '{1'b1,1'b0,32'h20,32'h0,2'd2, 1'b1,1'b0,32'h40,32'h0,2'd2,1'b0, 32'h108, 2'b01,1'b0,4'hF,1'b0,32'h108,32'h20};
        // Lock released because m1 drops its request
        vecs[25] = '{1'b0,1'b0,32'h0,32'h0,2'd0, 1'b1,1'b0,32'h40,32'h0,2'd2,1'b1, 32'h109, 2'b10,1'b0,4'hF,1'b0,32'h109,32'h40};
        vecs[26] = '{1'b1,1'b0,32'h20,32'h0,2'd2, 1'b0,1'b0,32'h0,32'h0,2'd0,1'b1, 32'h10A, 2'b01,1'b0,4'hF,1'b0,32'h10A,32'h20};
        vecs[27] = idle;

        // Reset held with both masters requesting: nothing may be granted
        reset = 1'b0;
        applyStimulus(vecs[0]);
        repeat (2) @(negedge clk);
        checkVal("reset gnt", {30'h0, m1_gnt, m0_gnt}, 32'h0);
        checkVal("reset dm_we", 32'(dm_we), 32'h0);
        checkVal("reset dm_be", 32'(dm_be), 32'h0);
        checkVal("reset dm_a", dm_a, 32'h0);
        checkVal("reset rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
        checkVal("reset err", {30'h0, m1_err, m0_err}, 32'h0);
        checkVal("reset rdata", m0_rdata | m1_rdata, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 28; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), vecs[i]);
            @(posedge clk);
            #1;
        end

        // A store whose grant edge lands inside reset must produce no response
        st = idle;
        st.m0Req = 1'b1;
        st.m0We = 1'b1;
        st.m0Addr = 32'h100;
        st.m0Wdata = 32'h1357_9BDF;
        st.m0Size = 2'd2;
        applyStimulus(st);
        @(negedge clk);
        checkVal("midreset gnt", {30'h0, m1_gnt, m0_gnt}, 32'h1);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        checkVal("midreset rvalid", 32'(m0_rvalid), 32'h0);
        checkVal("midreset gnt_low", 32'(m0_gnt), 32'h0);
        checkVal("midreset dm_we", 32'(dm_we), 32'h0);
        reset = 1'b1;
        applyStimulus(idle);
        @(negedge clk);
        checkOutput("postreset", idle);

        checkVal("queue empty", respQ.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
